ps2_note_scheduler: RTL and testbench

Sequences the PS/2 keyboard byte stream into note commands for the audio tone generator. It decodes make/break/extended prefixes into key events and tracks currently held keys in a small last-pressed-wins stack. It also enforces a minimum audible note length. It sits between the PS/2 receiver (byte + strobe) and the audio block's note/enable inputs, and exports decoded key events to the game logic.

---
 rtl/ps2_note_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_ps2_note_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_note_scheduler.sv
// ----------------------------------------------------------------------------
// ps2_note_scheduler
//
// Turns the PS/2 receiver byte stream into key events and note commands.
// A prefix decoder folds E0 (extended) and F0 (break) prefixes into the next
// scancode. Non-extended makes/breaks maintain a last-pressed-wins stack of
// held keys whose top drives the tone generator. An optional hold counter
// keeps the note audible for a minimum time after every push.
//
// Optional feature macro: NOTE_MIN_HOLD_EN (minimum note_on hold counter).
//
// Ports:
//   CLOCK_50    in   system clock, all state on the rising edge
//   resetn      in   asynchronous active-low reset
//   ps2_data    in   [7:0] byte from the PS/2 receiver
//   ps2_valid   in   one-cycle strobe qualifying ps2_data
//   note_code   out  [7:0] scancode of the note to play
//   note_on     out  audio enable
//   key_event   out  one-cycle strobe per completed key event
//   key_code    out  [7:0] scancode of the last event
//   key_release out  last event was a break
//   key_ext     out  last event was E0-extended
// ----------------------------------------------------------------------------
module ps2_note_scheduler #(
    parameter int DEPTH         = 4,
    parameter int MIN_ON_CYCLES = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    output logic [7:0] note_code,
    output logic       note_on,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_ext
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t     state_q, state_d;
    logic       ext_f, brk_f, done;

    logic [7:0] stack_q [DEPTH];
    logic [7:0] stack_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic       push;
    logic       hit;
    int         hit_idx;
    logic [7:0] top_d;
    logic       on_d;

    // ------------------------------------------------------------------
    // Prefix decoder: next state and event completion
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        ext_f   = (state_q == EXT) || (state_q == EXT_BRK);
        brk_f   = (state_q == BRK) || (state_q == EXT_BRK);
        if (ps2_valid) begin
            case (ps2_data)
                8'hE0:        state_d = brk_f ? EXT_BRK : EXT;
                8'hF0:        state_d = ext_f ? EXT_BRK : BRK;
                8'h00, 8'hFF: state_d = IDLE;   // receiver error: drop prefixes
                default: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Held-key stack: index 0 is the oldest key, cnt_q-1 is the top
    // ------------------------------------------------------------------
    always_comb begin
        stack_d = stack_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        hit     = 1'b0;
        hit_idx = 0;
        top_d   = note_code;

        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && i < int'(cnt_q) && stack_q[i] == ps2_data) begin
                hit     = 1'b1;
                hit_idx = i;
            end
        end

        // Extended keys (arrows etc.) are reported but never played.
        if (done && !ext_f) begin
            if (!brk_f && !hit) begin
                push = 1'b1;
                if (int'(cnt_q) == DEPTH) begin
                    // Full: evict the oldest key and push on top.
                    for (int i = 0; i < DEPTH - 1; i++)
                        stack_d[i] = stack_q[i + 1];
                    stack_d[DEPTH-1] = ps2_data;
                end else begin
                    for (int i = 0; i < DEPTH; i++)
                        if (i == int'(cnt_q))
                            stack_d[i] = ps2_data;
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (brk_f && hit) begin
                // Remove the released key, closing the gap toward the bottom.
                for (int i = 0; i < DEPTH - 1; i++)
                    if (i >= hit_idx)
                        stack_d[i] = stack_q[i + 1];
                stack_d[DEPTH-1] = 8'h00;
                cnt_d = cnt_q - 1'b1;
            end
        end

        for (int i = 0; i < DEPTH; i++)
            if (i == int'(cnt_d) - 1)
                top_d = stack_d[i];
    end

    // ------------------------------------------------------------------
    // Note enable, with or without the minimum hold time
    // ------------------------------------------------------------------
`ifdef NOTE_MIN_HOLD_EN
    localparam int HW = $clog2(MIN_ON_CYCLES + 1);

    logic [HW-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (push)
            hold_d = HW'(MIN_ON_CYCLES);
        else if (hold_q != '0)
            hold_d = hold_q - 1'b1;
    end

    assign on_d = (cnt_d != '0) || (hold_d != '0);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) hold_q <= '0;
        else         hold_q <= hold_d;
    end
`else
    assign on_d = (cnt_d != '0);
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            // NOTE: the stack is only a few bytes, so it is reset along with
            // everything else; entries above cnt_q are never read anyway.
            for (int i = 0; i < DEPTH; i++)
                stack_q[i] <= 8'h00;
            note_code   <= 8'h00;
            note_on     <= 1'b0;
            key_event   <= 1'b0;
            key_code    <= 8'h00;
            key_release <= 1'b0;
            key_ext     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stack_q   <= stack_d;
            note_code <= top_d;
            note_on   <= on_d;
            key_event <= done;
            if (done) begin
                key_code    <= ps2_data;
                key_release <= brk_f;
                key_ext     <= ext_f;
            end
        end
    end

endmodule

// File: tb/tb_ps2_note_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ps2_note_scheduler
//
// Self-checking bench for ps2_note_scheduler (DEPTH=4, MIN_ON_CYCLES=16).
// A queue-based reference model tracks prefixes, held keys and the hold
// timer; each scenario task compares the DUT against it and against fixed
// expectations. Honours NOTE_MIN_HOLD_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_ps2_note_scheduler;

    localparam int DEPTH   = 4;
    localparam int MIN_ON  = 16;
`ifdef NOTE_MIN_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] ps2_data;
    logic       ps2_valid;
    logic [7:0] note_code;
    logic       note_on;
    logic       key_event;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_ext;

    int checks = 0;
    int errors = 0;

    ps2_note_scheduler #(.DEPTH(DEPTH), .MIN_ON_CYCLES(MIN_ON)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .ps2_data   (ps2_data),
        .ps2_valid  (ps2_valid),
        .note_code  (note_code),
        .note_on    (note_on),
        .key_event  (key_event),
        .key_code   (key_code),
        .key_release(key_release),
        .key_ext    (key_ext)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] held[$];          // held[0] oldest, held[$] newest
    bit         pend_ext, pend_brk;
    int         hold_left;
    logic [7:0] m_note_code, m_key_code;
    bit         m_note_on, m_key_event, m_key_release, m_key_ext;

    function automatic void model_reset();
        held.delete();
        pend_ext = 0; pend_brk = 0; hold_left = 0;
        m_note_code = 8'h00; m_key_code = 8'h00;
        m_note_on = 0; m_key_event = 0; m_key_release = 0; m_key_ext = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] d);
        bit pushed = 0;
        int idx = -1;
        m_key_event = 0;
        if (v) begin
            if (d == 8'hE0)                     pend_ext = 1;
            else if (d == 8'hF0)                pend_brk = 1;
            else if (d == 8'h00 || d == 8'hFF) begin pend_ext = 0; pend_brk = 0; end
            else begin
                m_key_event = 1; m_key_code = d;
                m_key_release = pend_brk; m_key_ext = pend_ext;
                if (!pend_ext) begin
                    foreach (held[i]) if (idx < 0 && held[i] == d) idx = i;
                    if (!pend_brk && idx < 0) begin
                        if (held.size() == DEPTH) void'(held.pop_front());
                        held.push_back(d);
                        pushed = 1;
                    end else if (pend_brk && idx >= 0) begin
                        held.delete(idx);
                    end
                end
                pend_ext = 0; pend_brk = 0;
            end
        end
        if (pushed)             hold_left = MIN_ON;
        else if (hold_left > 0) hold_left--;
        if (held.size() != 0) m_note_code = held[held.size()-1];
        m_note_on = (held.size() != 0) || (HOLD_EN && hold_left != 0);
    endfunction

    function automatic logic [19:0] exp_vec();
        return {m_key_event, m_key_code, m_key_release, m_key_ext, m_note_code, m_note_on};
    endfunction

    wire [19:0] dut_vec = {key_event, key_code, key_release, key_ext, note_code, note_on};

    // One clock: drive at negedge, update the model at posedge, settle 1 ns.
    task automatic drive(input bit v, input logic [7:0] d);
        @(negedge clk);
        ps2_valid = v;
        ps2_data  = d;
        @(posedge clk);
        model_step(v, d);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if (dut_vec !== 20'h0) begin
            errors++;
            $display("FAIL reset_state got=%h want=00000", dut_vec);
        end
    endtask

    task automatic test_min_hold();
        logic [7:0] seq[$] = '{8'h1C, 8'h00, 8'h00, 8'hF0, 8'h1C};
        bit exp_on;
        for (int n = 0; n < 20; n++) begin
            if (n < seq.size()) drive(seq[n] != 8'h00, seq[n]);
            else                drive(0, 8'h00);
            exp_on = HOLD_EN ? (n < MIN_ON) : (n < 4);
            checks++;
            if (note_on !== exp_on || note_code !== 8'h1C) begin
                errors++;
                $display("FAIL min_hold n=%0d note_on=%b note_code=%h want %b/1c",
                         n, note_on, note_code, exp_on);
            end
            if (n == 0 || n == 4) begin
                checks++;
                if (key_event !== 1'b1 || key_code !== 8'h1C || key_release !== (n == 4)) begin
                    errors++;
                    $display("FAIL min_hold_event n=%0d got ev=%b code=%h rel=%b",
                             n, key_event, key_code, key_release);
                end
            end
        end
    endtask

    task automatic test_stack_order();
        logic [7:0] seq[$]  = '{8'h1C, 8'h1B, 8'h23, 8'hF0, 8'h23, 8'hF0, 8'h1C, 8'hF0, 8'h1B};
        logic [7:0] want[$] = '{8'h1C, 8'h1B, 8'h23, 8'h23, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B};
        foreach (seq[i]) begin
            drive(1, seq[i]);
            checks++;
            if (dut_vec !== exp_vec() || note_code !== want[i]) begin
                errors++;
                $display("FAIL stack_order step=%0d got=%h want=%h note=%h", i, dut_vec, exp_vec(), want[i]);
            end
        end
        checks++;
        if (held.size() != 0 || (!HOLD_EN && note_on !== 1'b0)) begin
            errors++;
            $display("FAIL stack_empty note_on=%b held=%0d", note_on, held.size());
        end
        drive(0, 8'h00);
    endtask

    task automatic test_overflow();
        logic [7:0] seq[$] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'hF0, 8'h2C, 8'hF0, 8'h15};
        foreach (seq[i]) begin
            drive(1, seq[i]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL overflow step=%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            if (i == 4 || i == 6 || i == 8) begin
                checks++;
                if (note_code !== ((i == 4) ? 8'h2C : 8'h2D)) begin
                    errors++;
                    $display("FAIL overflow_top step=%0d got=%h", i, note_code);
                end
            end
        end
        // Release the three keys still held.
        foreach (seq[i]) if (i >= 1 && i <= 3) begin drive(1, 8'hF0); drive(1, seq[i]); end
        drive(0, 8'h00);
    endtask

    task automatic test_typematic();
        int pulses = 0;
        logic [7:0] seq[$] = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        foreach (seq[i]) begin
            drive(1, seq[i]);
            if (key_event === 1'b1) pulses++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL typematic step=%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        drive(0, 8'h00);
        checks++;
        if (pulses != 6 || held.size() != 0) begin
            errors++;
            $display("FAIL typematic_pulses got=%0d want=6", pulses);
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq[$] = '{8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                               8'hF0, 8'hFF, 8'h1C, 8'hF0, 8'h1C};
        foreach (seq[i]) begin
            drive(1, seq[i]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL extended step=%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        drive(0, 8'h00);
        // After F0,FF,1C the 1C was a make, so the final F0,1C emptied the stack
        // only because it was held; the E0 events left it alone.
        checks++;
        if (held.size() != 0 || key_code !== 8'h1C || key_release !== 1'b1 || key_ext !== 1'b0) begin
            errors++;
            $display("FAIL extended_final code=%h rel=%b ext=%b", key_code, key_release, key_ext);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 8'hF0);
        @(negedge clk);
        ps2_valid = 0;
        resetn    = 0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (dut_vec !== 20'h0) begin
                errors++;
                $display("FAIL reset_mid_hold cyc=%0d got=%h want=00000", i, dut_vec);
            end
        end
        @(negedge clk);
        resetn = 1;
        drive(1, 8'h1C);
        checks++;
        if (key_event !== 1'b1 || key_release !== 1'b0 || note_on !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_make got=%h want=%h", dut_vec, exp_vec());
        end
        drive(1, 8'hF0);
        drive(1, 8'h1C);
        drive(0, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] pool[13] = '{8'hE0, 8'hF0, 8'hF0, 8'h00, 8'hFF, 8'h1C, 8'h1B,
                                 8'h23, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h75};
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) drive(0, 8'($urandom));
            else                        drive(1, pool[$urandom_range(12)]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random n=%0d got=%h want=%h", n, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        resetn    = 0;
        ps2_valid = 0;
        ps2_data  = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1;
        test_reset();
        test_min_hold();
        test_stack_order();
        test_overflow();
        test_typematic();
        test_extended();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
